// File: rtl/divider.sv
// divider: sequential unsigned restoring divider, one quotient bit per clock.
//
// Shares the start/finished handshake of the shift-add multiplier. An operation
// is accepted from IDLE, runs BITS steps in RUN, then spends one cycle in DONE.
// During DONE o_finished is high. Results are loaded only on the finishing edge
// and are held until the next operation finishes.
//
// Optional feature macro: DIVIDER_ZERO_DETECT_EN. When it is defined, the design
// adds the o_divide_by_zero output. A zero divisor then finishes one cycle after
// the start edge.
//
// Ports:
//   i_clock          system clock, rising edge
//   i_reset          asynchronous, active-high reset
//   i_start          operation request, sampled only in IDLE
//   i_dividend       numerator, latched at the start edge
//   i_divisor        denominator, latched at the start edge
//   o_busy           high in RUN and DONE
//   o_finished       one-cycle pulse in DONE; results valid from this cycle on
//   o_quotient       floor(dividend / divisor)
//   o_remainder      dividend mod divisor
//   o_divide_by_zero (DIVIDER_ZERO_DETECT_EN only) last started op had divisor 0
module divider #(
  parameter int unsigned BITS = 4
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic [BITS-1:0] i_dividend,
  input  logic [BITS-1:0] i_divisor,
  output logic            o_busy,
  output logic            o_finished,
  output logic [BITS-1:0] o_quotient,
`ifdef DIVIDER_ZERO_DETECT_EN
  output logic [BITS-1:0] o_remainder,
  output logic            o_divide_by_zero
`else
  output logic [BITS-1:0] o_remainder
`endif
);

  localparam int unsigned CntW = $clog2(BITS + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [BITS-1:0]   q_q, q_d;      // dividend shifting out, quotient shifting in
  logic [BITS-1:0]   d_q, d_d;      // latched divisor
  // The restored remainder is always below the divisor, so its top bit is always
  // zero. Only the shifted trial value needs the extra bit.
  logic [BITS-1:0]   r_q, r_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BITS-1:0]   quot_q, quot_d;
  logic [BITS-1:0]   rem_q, rem_d;
`ifdef DIVIDER_ZERO_DETECT_EN
  logic              dbz_q, dbz_d;
`endif

  // One restoring step.
  logic [BITS:0]     r_shift;
  logic              fits;
  logic [BITS-1:0]   step_q;
  logic [BITS-1:0]   step_r;

  always_comb begin
    r_shift = {1'b0, r_q, q_q[BITS-1]};
    fits    = (r_shift >= {1'b0, d_q});
    step_q  = {q_q[BITS-2:0], fits};
    step_r  = fits ? BITS'(r_shift - {1'b0, d_q}) : r_shift[BITS-1:0];
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    d_d     = d_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
`ifdef DIVIDER_ZERO_DETECT_EN
    dbz_d   = dbz_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          q_d     = i_dividend;
          d_d     = i_divisor;
          r_d     = '0;
          cnt_d   = '0;
`ifdef DIVIDER_ZERO_DETECT_EN
          dbz_d   = 1'b0;
`endif
          state_d = StRun;
        end
      end
      StRun: begin
        q_d   = step_q;
        r_d   = step_r;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(BITS - 1)) begin
          quot_d  = step_q;
          rem_d   = step_r;
          state_d = StDone;
        end
`ifdef DIVIDER_ZERO_DETECT_EN
        // Zero divisor: skip the steps. q_q still holds the untouched dividend.
        if (d_q == '0) begin
          quot_d  = '1;
          rem_d   = q_q;
          dbz_d   = 1'b1;
          state_d = StDone;
        end
`endif
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= StIdle;
      q_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
`ifdef DIVIDER_ZERO_DETECT_EN
      dbz_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      d_q     <= d_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
`ifdef DIVIDER_ZERO_DETECT_EN
      dbz_q   <= dbz_d;
`endif
    end
  end

  // Status outputs are decoded from the state. Reset therefore clears them without a clock edge.
  assign o_busy      = (state_q != StIdle);
  assign o_finished  = (state_q == StDone);
  assign o_quotient  = quot_q;
  assign o_remainder = rem_q;
`ifdef DIVIDER_ZERO_DETECT_EN
  assign o_divide_by_zero = dbz_q;
`endif

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider with BITS=4. It uses table-driven vectors and
// a scoreboard of expected results, which are checked when o_finished pulses.
module tb_divider;

  localparam int unsigned BITS = 4;

  logic            clk;
  logic            i_reset;
  logic            i_start;
  logic [BITS-1:0] i_dividend;
  logic [BITS-1:0] i_divisor;
  logic            o_busy;
  logic            o_finished;
  logic [BITS-1:0] o_quotient;
  logic [BITS-1:0] o_remainder;
`ifdef DIVIDER_ZERO_DETECT_EN
  logic            o_divide_by_zero;
`endif

  divider #(.BITS(BITS)) dut (
    .i_clock          (clk),
    .i_reset          (i_reset),
    .i_start          (i_start),
    .i_dividend       (i_dividend),
    .i_divisor        (i_divisor),
    .o_busy           (o_busy),
    .o_finished       (o_finished),
    .o_quotient       (o_quotient),
`ifdef DIVIDER_ZERO_DETECT_EN
    .o_remainder      (o_remainder),
    .o_divide_by_zero (o_divide_by_zero)
`else
    .o_remainder      (o_remainder)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [BITS-1:0] q;
    logic [BITS-1:0] r;
    int              start_cyc;
    int              lat;
    logic            dbz;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [BITS-1:0] a;
    logic [BITS-1:0] b;
    logic [BITS-1:0] q;
    logic [BITS-1:0] r;
  } vec_t;
  vec_t vecs[$];

  bit running = 1'b0;
  logic [BITS-1:0] last_q;
  logic [BITS-1:0] last_r;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int lat_for(input logic [BITS-1:0] b);
`ifdef DIVIDER_ZERO_DETECT_EN
    return (b == '0) ? 1 : BITS;
`else
    return (b == '0) ? BITS : BITS;
`endif
  endfunction

  // Monitor: sample on the falling edge. Compare each finish pulse against the
  // scoreboard, and check o_busy while operations are pending.
  bit prev_fin = 1'b0;
  always @(negedge clk) begin
    if (running && !i_reset) begin
      if (o_finished) begin
        check("single_cycle_finish", {31'd0, prev_fin}, 32'd0);
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_finish: got pulse expected none (t=%0t)", $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("quotient", {28'd0, o_quotient}, {28'd0, e.q});
          check("remainder", {28'd0, o_remainder}, {28'd0, e.r});
          check("latency", cyc - e.start_cyc, e.lat);
          check("busy_in_done", {31'd0, o_busy}, 32'd1);
`ifdef DIVIDER_ZERO_DETECT_EN
          check("divide_by_zero", {31'd0, o_divide_by_zero}, {31'd0, e.dbz});
`endif
        end
      end else if (sb.size() > 0 && cyc >= sb[0].start_cyc) begin
        check("busy_in_run", {31'd0, o_busy}, 32'd1);
      end else if (sb.size() == 0) begin
        check("idle_not_busy", {31'd0, o_busy}, 32'd0);
      end
      prev_fin = o_finished;
    end else begin
      prev_fin = 1'b0;
    end
  end

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got %0d pending expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  // Called at a falling edge. Runs one operation to completion.
  task automatic do_op(input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                       input logic [BITS-1:0] q, input logic [BITS-1:0] r);
    int n = 0;
    while (o_busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    i_start    = 1'b1;
    i_dividend = a;
    i_divisor  = b;
    sb.push_back('{q: q, r: r, start_cyc: cyc + 1, lat: lat_for(b), dbz: (b == '0)});
    @(negedge clk);
    i_start    = 1'b0;
    i_dividend = ~a;
    i_divisor  = ~b;
`ifdef DIVIDER_ZERO_DETECT_EN
    check("dbz_cleared_on_start", {31'd0, o_divide_by_zero}, 32'd0);
`endif
    wait_drain("op");
    last_q = q;
    last_r = r;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    i_reset    = 1'b1;
    i_start    = 1'b0;
    i_dividend = '0;
    i_divisor  = '0;
    #1;
    check("reset_busy", {31'd0, o_busy}, 32'd0);
    check("reset_finished", {31'd0, o_finished}, 32'd0);
    check("reset_quotient", {28'd0, o_quotient}, 32'd0);
    check("reset_remainder", {28'd0, o_remainder}, 32'd0);
`ifdef DIVIDER_ZERO_DETECT_EN
    check("reset_dbz", {31'd0, o_divide_by_zero}, 32'd0);
`endif
    @(negedge clk);
    i_reset = 1'b0;
    running = 1'b1;
    @(negedge clk);

    // Basic operation.
    do_op(4'd13, 4'd4, 4'd3, 4'd1);

    // Back-to-back with i_start held high. The operands change mid-RUN.
    @(negedge clk);
    c0         = cyc;
    i_start    = 1'b1;
    i_dividend = 4'd5;
    i_divisor  = 4'd7;
    sb.push_back('{q: 4'd0, r: 4'd5, start_cyc: c0 + 1, lat: BITS, dbz: 1'b0});
    sb.push_back('{q: 4'd15, r: 4'd0, start_cyc: c0 + 7, lat: BITS, dbz: 1'b0});
    @(negedge clk);
    i_dividend = 4'd15;
    i_divisor  = 4'd1;
    repeat (6) @(negedge clk);
    i_start = 1'b0;
    wait_drain("back_to_back");

    // Reset asserted between steps 2 and 3 of 14/3.
    @(negedge clk);
    c0         = cyc;
    i_start    = 1'b1;
    i_dividend = 4'd14;
    i_divisor  = 4'd3;
    sb.push_back('{q: 4'd4, r: 4'd2, start_cyc: c0 + 1, lat: BITS, dbz: 1'b0});
    @(negedge clk);
    i_start = 1'b0;
    repeat (2) @(negedge clk);
    i_reset = 1'b1;
    sb.delete();
    #1;
    check("midreset_busy", {31'd0, o_busy}, 32'd0);
    check("midreset_finished", {31'd0, o_finished}, 32'd0);
    check("midreset_quotient", {28'd0, o_quotient}, 32'd0);
    check("midreset_remainder", {28'd0, o_remainder}, 32'd0);
    #1;
    i_reset = 1'b0;
    @(negedge clk);
    do_op(4'd14, 4'd3, 4'd4, 4'd2);

    // Vector table: an exhaustive sweep first, then hand-picked corners.
    for (int x = 0; x < 16; x++) begin
      for (int y = 1; y < 16; y++) begin
        vecs.push_back('{a: 4'(x), b: 4'(y), q: 4'(x / y), r: 4'(x % y)});
      end
    end
    vecs.push_back('{a: 4'd9,  b: 4'd0,  q: 4'd15, r: 4'd9});
    vecs.push_back('{a: 4'd0,  b: 4'd0,  q: 4'd15, r: 4'd0});
    vecs.push_back('{a: 4'd15, b: 4'd0,  q: 4'd15, r: 4'd15});
    vecs.push_back('{a: 4'd0,  b: 4'd5,  q: 4'd0,  r: 4'd0});
    vecs.push_back('{a: 4'd15, b: 4'd15, q: 4'd1,  r: 4'd0});
    vecs.push_back('{a: 4'd14, b: 4'd5,  q: 4'd2,  r: 4'd4});
    for (int i = 0; i < vecs.size(); i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r);
    end

    // Idle for 20 cycles with i_start low. The results must hold.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("hold_finished", {31'd0, o_finished}, 32'd0);
      check("hold_quotient", {28'd0, o_quotient}, {28'd0, last_q});
      check("hold_remainder", {28'd0, o_remainder}, {28'd0, last_r});
    end

    check("scoreboard_empty", sb.size(), 32'd0);
    running = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
